// File: rtl/disp_pkg.sv
// disp_pkg: shared glyphs, enable constants and digit index type for the mm:ss display
package disp_pkg;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;
  // Out-of-range tens become 4'hf so the decoder renders them as a dash
  function automatic logic [3:0] tens_digit(input logic [2:0] t);
    return t > 3'd5 ? 4'hf : {1'b0, t};
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a}, dash for 10-15
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/disp_scan_mmss.sv
// disp_scan_mmss: 4-digit multiplexed mm:ss common-anode driver with per-frame snapshot
module disp_scan_mmss
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [DW-1:0] div;
  digit_idx_t    idx;
  logic [13:0]   snap;
  logic          primed;
  logic          tick;
  logic          off;
  logic [3:0]    digit;
  logic [6:0]    glyph;
  always_comb begin
    tick  = div == DW'(SCAN_DIV - 1);
    digit = idx == 2'd0 ? snap[3:0] :
            idx == 2'd1 ? tens_digit(snap[6:4]) :
            idx == 2'd2 ? snap[10:7] : tens_digit(snap[13:11]);
    off   = blank || (BLANK_LZ && idx == 2'd3 && snap[13:11] == 3'd0);
  end
  bcd_to_seg7 u_dec (.digit(digit), .seg(glyph));
  // Snapshot reloads on the same edge idx wraps to 0, so every frame is coherent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      idx    <= '0;
      snap   <= '0;
      primed <= 1'b0;
      an     <= AN_OFF;
      seg    <= SEG_OFF;
      dp     <= 1'b1;
    end else begin
      div    <= tick ? '0 : div + 1'b1;
      idx    <= idx + digit_idx_t'(tick);
      primed <= 1'b1;
      if (!primed || (tick && idx == 2'd3)) snap <= {min, sec};
      an     <= off ? AN_OFF : ~(4'b0001 << idx);
      seg    <= off ? SEG_OFF : glyph;
      dp     <= ~(!blank && idx == 2'd2 && !snap[0]);
    end
  end
endmodule

// File: tb/tb_disp_scan_mmss.sv
// tb_disp_scan_mmss: randomized and directed checks of disp_scan_mmss against a frame-counting model
module tb_disp_scan_mmss;
  localparam int S = 4;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] sec = '0, min = '0;
  logic blank = 1'b0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic dp1, dp0;
  int checks = 0, errors = 0;
  bit run = 0;
  disp_scan_mmss #(.SCAN_DIV(S), .BLANK_LZ(1'b1)) dut (.clk(clk), .rst(rst), .sec(sec), .min(min),
    .blank(blank), .an(an1), .seg(seg1), .dp(dp1));
  disp_scan_mmss #(.SCAN_DIV(S), .BLANK_LZ(1'b0)) dut_nolz (.clk(clk), .rst(rst), .sec(sec), .min(min),
    .blank(blank), .an(an0), .seg(seg0), .dp(dp0));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s at %0t: got %b want %b", tag, $time, got, exp);
    end
  endtask
  function automatic void model_out(input logic [13:0] s, input int slot, input logic b, input bit lz,
                                    output logic [3:0] a, output logic [6:0] g, output logic d);
    int v;
    bit ok;
    case (slot)
      0: begin v = int'(s[3:0]);   ok = v <= 9; end
      1: begin v = int'(s[6:4]);   ok = v <= 5; end
      2: begin v = int'(s[10:7]);  ok = v <= 9; end
      default: begin v = int'(s[13:11]); ok = v <= 5; end
    endcase
    a = AN_TAB[slot];
    g = ok ? GLYPH[v] : 7'b0111111;
    if (b || (lz && slot == 3 && v == 0)) begin a = 4'hf; g = 7'h7f; end
    d = !(!b && slot == 2 && !s[0]);
  endfunction
  // k counts edges since reset release; slot and reload points follow from k alone
  int k = 0;
  logic [13:0] msnap = '0;
  logic [3:0] ea1 = 4'hf, ea0 = 4'hf;
  logic [6:0] es1 = 7'h7f, es0 = 7'h7f;
  logic ed1 = 1'b1, ed0 = 1'b1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; msnap = '0;
      ea1 = 4'hf; ea0 = 4'hf; es1 = 7'h7f; es0 = 7'h7f; ed1 = 1'b1; ed0 = 1'b1;
    end else begin
      k++;
      model_out(msnap, ((k - 1) / S) % 4, blank, 1'b1, ea1, es1, ed1);
      model_out(msnap, ((k - 1) / S) % 4, blank, 1'b0, ea0, es0, ed0);
      if (k == 1 || k % (4 * S) == 0) msnap = {min, sec};
    end
  end
  always @(negedge clk) begin
    if (run) begin
      check("an", {3'b0, an1}, {3'b0, ea1});
      check("seg", seg1, es1);
      check("dp", {6'b0, dp1}, {6'b0, ed1});
      check("an_nolz", {3'b0, an0}, {3'b0, ea0});
      check("seg_nolz", seg0, es0);
      check("dp_nolz", {6'b0, dp0}, {6'b0, ed0});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset(input int hold);
    #2 rst = 1'b0;
    #1;
    check("rst_an", {3'b0, an1}, 7'h0f);
    check("rst_seg", seg1, 7'h7f);
    check("rst_dp", {6'b0, dp1}, 7'h01);
    cyc(hold);
    #2 rst = 1'b1;
  endtask
  initial begin
    cyc(2);
    run = 1;
    sec = {3'd4, 4'd2}; min = {3'd1, 4'd7};
    #2 rst = 1'b1;
    cyc(3 * 4 * S);
    min = {3'd0, 4'd5};
    cyc(3 * 4 * S);
    sec = {3'd5, 4'd9}; min = {3'd5, 4'd9};
    cyc(4 * S + S + 1);
    sec = '0; min = '0;
    cyc(3 * 4 * S);
    sec = {3'd6, 4'd12};
    cyc(3 * 4 * S);
    sec = {3'd3, 4'd4};
    cyc(S + 1);
    blank = 1'b1;
    cyc(3);
    blank = 1'b0;
    cyc(2 * 4 * S + 2 * S);
    do_reset(2);
    cyc(3 * 4 * S);
    for (int i = 0; i < 150; i++) begin
      cyc(int'($urandom_range(1, 12)));
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          sec = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
          min = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end
        3: begin sec = 7'($urandom); min = 7'($urandom); end
        4: min = {3'd0, 4'($urandom_range(0, 9))};
        5, 6: blank = ~blank;
        7: if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 3)));
        default: sec[0] = ~sec[0];
      endcase
    end
    blank = 1'b0;
    cyc(4 * S);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_scan_mmss.md
# disp_scan_mmss

Multiplexed four-digit seven-segment display driver for the minutes:seconds clock. Consumes the packed BCD outputs of two chained 60-counters (seconds and minutes) and time-multiplexes them onto a common-anode display, one digit per scan slot. Inputs are snapshotted once per scan frame so a counter rollover never tears a frame. It sits directly downstream of the counter chain and drives the board pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_LZ`, default 1: when 1, blank the minutes-tens digit if it is 0.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `sec`, in, 7: seconds as packed BCD, {tens[2:0], ones[3:0]}.
- `min`, in, 7: minutes as packed BCD, {tens[2:0], ones[3:0]}.
- `blank`, in, 1: 1 = all digits off; the scan keeps running.
- `an`, out, 4: digit enables, active-low; an[0] is the rightmost digit.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, out, 1: decimal point / colon, active-low.

## Operation
- **Divider.** `div` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `div` = SCAN_DIV-1.
- **Digit index.** `idx` (2 bits) advances 0→1→2→3→0 on each `tick`.
- **Digit mapping.**
  - idx0: sec ones.
  - idx1: sec tens.
  - idx2: min ones.
  - idx3: min tens.
- **Snapshot.** Register `snap` = {min, sec}.
  - Loaded on the first clock after reset release, via a `primed` flag that is 0 in reset.
  - Thereafter loaded on each `tick` where idx = 3, so the frame restarts at idx0 with fresh data.
  - Input changes between loads are never displayed.
- **Decode.**
  - BCD 0–9 maps to the standard glyphs; for example, 0 → seg = 7'b1000000 and 8 → 7'b0000000.
  - Any ones nibble above 9, or tens value above 5, displays a dash, seg = 7'b0111111.
- **Blanking.**
  - If BLANK_LZ = 1, idx = 3 and the snapshot min tens = 0: an = 4'b1111, seg = 7'b1111111.
  - `blank` = 1: an = 4'b1111, seg = 7'b1111111, dp = 1, regardless of idx.
- **Colon.** dp = 0 only when idx = 2 and the snapshot sec ones[0] = 0. This gives a 1 s on / 1 s off blink. Otherwise dp = 1.
- **Enables.** When a digit is shown, an is one-hot-low at bit idx.

## Timing
- **Reset values.** an = 4'b1111, seg = 7'b1111111, dp = 1, div = 0, idx = 0, snap = 0, primed = 0.
- **Registered outputs.** `an`, `seg` and `dp` are registered from `idx`, `snap` and `blank`, so they have 1-cycle latency.
- **First edge after reset release.**
  - primed ← 1 and snap ← inputs.
  - Outputs show idx0 using the *pre-load* snap (0), i.e. an = 4'b1110 and seg = the 0 glyph.
  - From the second edge onward, outputs reflect the loaded snap.
- **Slot length.** Each digit is driven for exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.
- **Snapshot cadence.** The snap load and the idx 3→0 change occur on the same edge. The idx0 output carrying new data appears one cycle later.
- **`blank` response.** A change on `blank` takes effect on outputs at the next edge, with no effect on div, idx or snap.
- **Reset mid-frame.** The asynchronous reset immediately forces all outputs off and zeroes all state. No partial-frame state survives.
- **Wrap-around.** An input change of 59:59→00:00 mid-frame is shown only from the next frame start.

## Structure
- **Shared package `disp_pkg`.**
  - Segment glyph constants: SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Constant AN_OFF = 4'b1111.
  - typedef `digit_idx_t` (2-bit).
- **Sub-module `bcd_to_seg7`.** Purely combinational: 4-bit digit in, 7-bit active-low seg out, dash for values 10–15. Tens validity (> 5 → dash) is checked in the parent before the call.
- **Top level.** Holds the divider, idx, snapshot/primed registers, output mux and output registers.

## Test plan
Benches use SCAN_DIV = 4.
1. **Basic scan.** Reset, then release with sec = {3'd4,4'd2} and min = {3'd1,4'd7} held. Require:
   - the an sequence 1110, 1101, 1011, 0111, 4 cycles each;
   - seg glyphs 2, 4, 7, 1;
   - dp = 0 during the idx2 slot (sec ones = 2 is even).
2. **Leading zero.** Repeat with min = {3'd0,4'd5}, BLANK_LZ = 1. Require an = 1111 and seg = 1111111 for the idx3 slot. With BLANK_LZ = 0, require an = 0111 and seg = 1000000.
3. **Snapshot integrity.** Change sec from 59 to 00 during the idx1 slot. Require:
   - the remainder of that frame shows the old values (idx2 and idx3 from the old snapshot);
   - the next frame shows 0, 0 for idx0 and idx1.
4. **Invalid BCD.** Apply sec = {3'd6,4'd12}. Require the dash glyph 0111111 in both the idx0 and idx1 slots.
5. **Blank.** Pulse `blank` high for 3 cycles mid-slot. Require an = 1111, seg = 1111111 and dp = 1 one cycle later, with no idx or slot-boundary shift.
6. **Reset mid-frame.** Assert rst low asynchronously during idx2. Require outputs off immediately. After release, the first displayed digit is idx0 with the seg = 0 glyph, then fresh data from the second cycle.
